// File: rtl/ctrl_fault_pkg.sv
// rtl/ctrl_fault_pkg.sv - shared types, location/op constants and fault operator for ctrl_fault_unit
package ctrl_fault_pkg;

   typedef enum logic [1:0] {FT_NONE, FT_SA0, FT_SA1, FT_FLIP} f_type_e;

   localparam logic [2:0] LOC_B0   = 3'd0;
   localparam logic [2:0] LOC_B1   = 3'd1;
   localparam logic [2:0] LOC_B2   = 3'd2;
   localparam logic [2:0] LOC_B3   = 3'd3;
   localparam logic [2:0] LOC_CIN  = 3'd4;
   localparam logic [2:0] LOC_LESS = 3'd5;
   localparam logic [2:0] LOC_Y0   = 3'd6;
   localparam logic [2:0] LOC_Y7   = 3'd7;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   function automatic logic fault_bit(input logic x, input f_type_e t);
      case (t)
         FT_SA0:  fault_bit = 1'b0;
         FT_SA1:  fault_bit = 1'b1;
         FT_FLIP: fault_bit = ~x;
         default: fault_bit = x;
      endcase
   endfunction

endpackage

// File: rtl/fault_alu8.sv
// rtl/fault_alu8.sv - combinational MIPS-style ALU slice with single-node fault hooks
module fault_alu8
   import ctrl_fault_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [3:0]       B,
   input  logic [WIDTH-1:0] C,
   input  logic [2:0]       f_loc,
   input  logic [1:0]       f_type,
   output logic [WIDTH-1:0] Y
);

   f_type_e          ft;
   logic [3:0]       bp;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic             cin;
   logic             ovf;
   logic             less;

   always_comb begin
      ft = f_type_e'(f_type);
      // Control bits are faulted ahead of decode so the fault propagates everywhere they steer.
      bp = B;
      if (f_loc <= LOC_B3)
         bp[f_loc[1:0]] = fault_bit(B[f_loc[1:0]], ft);

      a   = bp[3] ? ~A : A;
      b   = bp[2] ? ~C : C;
      cin = bp[2];
      if (f_loc == LOC_CIN)
         cin = fault_bit(bp[2], ft);

      sum  = a + b + {{(WIDTH-1){1'b0}}, cin};
      ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      less = sum[WIDTH-1] ^ ovf;
      if (f_loc == LOC_LESS)
         less = fault_bit(less, ft);

      case (bp[1:0])
         OP_AND:  Y = a & b;
         OP_OR:   Y = a | b;
         OP_ADD:  Y = sum;
         default: Y = {{(WIDTH-1){1'b0}}, less};
      endcase

      if (f_loc == LOC_Y0)
         Y[0] = fault_bit(Y[0], ft);
      if (f_loc == LOC_Y7)
         Y[WIDTH-1] = fault_bit(Y[WIDTH-1], ft);
   end

endmodule

// File: rtl/ctrl_fault_unit.sv
// rtl/ctrl_fault_unit.sv - faulty/golden ALU pair with sticky fault status; FAULT_CNT_EN adds fault_cnt
module ctrl_fault_unit
   import ctrl_fault_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [3:0]       B,
   input  logic [2:0]       f_loc,
   input  logic [1:0]       f_type,
   input  logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] Y,
`ifdef FAULT_CNT_EN
   output logic [7:0]       fault_cnt,
`endif
   output logic             fault_hit
);

   logic [WIDTH-1:0] y_gold;
   logic             diff;

   fault_alu8 #(.WIDTH(WIDTH)) u_faulty (
      .A(A), .B(B), .C(C), .f_loc(f_loc), .f_type(f_type), .Y(Y)
   );

   fault_alu8 #(.WIDTH(WIDTH)) u_golden (
      .A(A), .B(B), .C(C), .f_loc(f_loc), .f_type(FT_NONE), .Y(y_gold)
   );

   assign diff = (Y != y_gold);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         fault_hit <= 1'b0;
      else if (diff)
         fault_hit <= 1'b1;
   end

`ifdef FAULT_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         fault_cnt <= 8'd0;
      else if (diff && fault_cnt != 8'hFF)
         fault_cnt <= fault_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_ctrl_fault_unit.sv
// tb/tb_ctrl_fault_unit.sv - randomized and directed checks of ctrl_fault_unit against a behavioural model
module tb_ctrl_fault_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] A, C, Y;
   logic [3:0] B;
   logic [2:0] f_loc;
   logic [1:0] f_type;
   logic       fault_hit;
`ifdef FAULT_CNT_EN
   logic [7:0] fault_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit hit_m  = 1'b0;
   int cnt_m  = 0;

   ctrl_fault_unit dut (
      .clk(clk), .reset(reset), .A(A), .B(B), .f_loc(f_loc), .f_type(f_type), .C(C), .Y(Y),
`ifdef FAULT_CNT_EN
      .fault_cnt(fault_cnt),
`endif
      .fault_hit(fault_hit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit flt(input bit x, input int ft);
      case (ft)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return ~x;
         default: return x;
      endcase
   endfunction

   // Reference ALU: the SLT "less" bit is the sign of the exact signed sum.
   function automatic logic [7:0] ref_alu(input logic [7:0] ai, input logic [3:0] ctl,
                                          input logic [7:0] ci, input int loc, input int ft);
      logic [3:0] k;
      logic [7:0] ao, bo, yr;
      int         cin, s;
      bit         less;
      k = ctl;
      if (loc < 4) k[loc] = flt(k[loc], ft);
      ao  = k[3] ? ~ai : ai;
      bo  = k[2] ? ~ci : ci;
      cin = int'(k[2]);
      if (loc == 4) cin = int'(flt(k[2], ft));
      s    = int'($signed(ao)) + int'($signed(bo)) + cin;
      less = (s < 0);
      if (loc == 5) less = flt(less, ft);
      case (k[1:0])
         2'd0:    yr = ao & bo;
         2'd1:    yr = ao | bo;
         2'd2:    yr = 8'((int'(ao) + int'(bo) + cin) % 256);
         default: yr = {7'd0, less};
      endcase
      if (loc == 6) yr[0] = flt(yr[0], ft);
      if (loc == 7) yr[7] = flt(yr[7], ft);
      return yr;
   endfunction

   task automatic step(input logic [7:0] a_i, input logic [3:0] b_i, input logic [7:0] c_i,
                       input int loc, input int ft);
      logic [7:0] yf, yg;
      @(negedge clk);
      A = a_i; B = b_i; C = c_i; f_loc = 3'(loc); f_type = 2'(ft);
      yf = ref_alu(a_i, b_i, c_i, loc, ft);
      yg = ref_alu(a_i, b_i, c_i, loc, 0);
      #2 check("y", int'(Y), int'(yf));
      @(posedge clk);
      if (yf != yg) begin
         hit_m = 1'b1;
         if (cnt_m < 255) cnt_m++;
      end
      #1 check("fault_hit", int'(fault_hit), int'(hit_m));
`ifdef FAULT_CNT_EN
      check("fault_cnt", int'(fault_cnt), cnt_m);
`endif
   endtask

   task automatic plan(input logic [7:0] a_i, input logic [3:0] b_i, input logic [7:0] c_i,
                       input int loc, input int ft, input logic [7:0] y_exp);
      step(a_i, b_i, c_i, loc, ft);
      check("plan_y", int'(Y), int'(y_exp));
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1 check("rst_hit", int'(fault_hit), 0);
`ifdef FAULT_CNT_EN
      check("rst_cnt", int'(fault_cnt), 0);
`endif
      check("rst_y", int'(Y), int'(ref_alu(A, B, C, int'(f_loc), int'(f_type))));
      hit_m = 1'b0;
      cnt_m = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      A = 8'h00; B = 4'h0; C = 8'h00; f_loc = 3'd0; f_type = 2'd0;
      #3 check("reset_hit", int'(fault_hit), 0);
`ifdef FAULT_CNT_EN
      check("reset_cnt", int'(fault_cnt), 0);
`endif
      @(negedge clk);
      reset = 1'b1;

      plan(8'h0F, 4'b0010, 8'h05, 0, 0, 8'h14);
      check("hit_clean", int'(fault_hit), 0);
      plan(8'h0F, 4'b0010, 8'h05, 3, 2, 8'hF5);
      plan(8'h0F, 4'b0110, 8'h05, 0, 0, 8'h0A);
      pulse_reset();
      plan(8'hF0, 4'b0001, 8'h3C, 0, 1, 8'h30);
      check("hit_set", int'(fault_hit), 1);
      plan(8'hF0, 4'b0001, 8'h3C, 0, 0, 8'hFC);
      check("hit_sticky", int'(fault_hit), 1);
      plan(8'h03, 4'b0111, 8'h05, 0, 0, 8'h01);
      plan(8'h03, 4'b0111, 8'h05, 5, 3, 8'h00);
      plan(8'h80, 4'b0111, 8'h01, 0, 0, 8'h01);
      plan(8'h01, 4'b0010, 8'h01, 4, 2, 8'h03);
      plan(8'h01, 4'b0010, 8'h01, 7, 2, 8'h82);
      plan(8'h01, 4'b0010, 8'h01, 6, 3, 8'h03);
      plan(8'h55, 4'b1100, 8'h0F, 0, 0, 8'hA0);
      pulse_reset();

      for (int i = 0; i < 400; i++) begin
         step(8'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)));
         if (i % 100 == 99) pulse_reset();
      end

`ifdef FAULT_CNT_EN
      for (int i = 0; i < 300; i++)
         step(8'hF0, 4'b0001, 8'h3C, 0, 1);
      check("cnt_sat", int'(fault_cnt), 255);
      pulse_reset();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_fault_unit.md
Name: ctrl_fault_unit

Overview:
- 8-bit MIPS-style ALU slice with programmable single-fault injection on its control lines and selected datapath nodes. Used for fault-effect studies.
- Y is combinational and carries the faulty result.
- A fault-free golden copy runs in parallel and drives a registered sticky "fault observed" status.
- Sits beside the ALU test harness.

Parameters:
- WIDTH, 8, datapath width (only 8 is required; SLT and bit-location mapping are defined for 8).

Ports:
- clk  in  1  clock; status registers only.
- reset  in  1  asynchronous reset, active-low.
- A  in  8  operand a.
- B  in  4  ALU control {ainvert, bnegate, op[1:0]}.
- f_loc  in  3  fault location select.
- f_type  in  2  fault type: 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip.
- C  in  8  operand b.
- Y  out  8  faulty ALU result, combinational.
- fault_hit  out  1  sticky flag, registered.

Behaviour:
- Fault operator f(x): type 00 gives x; 01 gives 0; 10 gives 1; 11 gives ~x. It is applied only at the node selected by f_loc.
- Fault locations:
  - 0..3: B[0]..B[3], faulted before decode; call the result B'.
  - 4: adder carry-in.
  - 5: SLT "less" bit.
  - 6: result bit Y[0] after the op mux.
  - 7: result bit Y[7] after the op mux.
- Datapath using B':
  - a = B'[3] ? ~A : A.
  - b = B'[2] ? ~C : C.
  - cin = B'[2], then faulted if f_loc = 4.
  - sum = a + b + cin, modulo 256.
- Op select B'[1:0]:
  - 00: a & b.
  - 01: a | b.
  - 10: sum.
  - 11: {7'b0, less}, where less = sum[7] ^ overflow, overflow = (a[7]==b[7]) && (sum[7]!=a[7]). less is faulted if f_loc = 5.
- Sample encodings: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
- Y is purely combinational from A, B, C, f_loc, f_type. Zero latency. There is no clock dependence, and Y is unaffected by reset.
- Golden path: identical logic with f_type forced to 00, producing Yg.
- fault_hit:
  - Async clear to 0 while reset is low.
  - Otherwise, on posedge clk: fault_hit <= fault_hit | (Y != Yg).
- f_type = 00 never changes Y, for any f_loc.
- Stuck-at a value equal to the fault-free node value gives no change.

Optional Feature:
- Macro FAULT_CNT_EN.
- Defined:
  - Adds output fault_cnt [7:0].
  - Async reset to 0 (active-low reset).
  - Increments on posedge clk when Y != Yg.
  - Saturates at 8'hFF with no wrap.
- Undefined: port and counter are absent; everything else is identical.

Decomposition:
- Package ctrl_fault_pkg holds:
  - typedef enum f_type_e {FT_NONE, FT_SA0, FT_SA1, FT_FLIP}.
  - Location constants LOC_B0..LOC_B3, LOC_CIN, LOC_LESS, LOC_Y0, LOC_Y7.
  - ALU op constants OP_AND, OP_OR, OP_ADD, OP_SLT.
- One sub-module, fault_alu8: the combinational ALU with fault hooks, instantiated twice (faulty and golden). The top adds the compare and status registers.

Test Plan:
- A=0x0F, C=0x05, B=0010, f_type=00 -> Y=0x14; fault_hit stays 0.
- Same operands, B=0010, f_loc=3, f_type=10 (ainvert stuck-1):
  - a=0xF0, b=0x05, cin=0, so Y=0xF5.
  - Then B=0110 with no fault -> Y=0x0A (subtract).
- A=0xF0, C=0x3C, B=0001, f_loc=0, f_type=01 (OR becomes AND) -> Y=0x30, golden 0xFC. fault_hit is 1 after the next posedge and stays 1 after returning to f_type=00.
- A=0x03, C=0x05, B=0111 (SLT) -> Y=0x01.
  - f_loc=5, f_type=11 -> Y=0x00.
  - A=0x80, C=0x01 with no fault -> Y=0x01 (signed).
- A=0x01, C=0x01, B=0010, f_loc=4, f_type=10 -> Y=0x03.
  - f_loc=7, f_type=10 -> Y=0x82.
  - f_loc=6, f_type=11 -> Y=0x03.
- Assert reset (low) asynchronously mid-cycle while a fault is active -> fault_hit (and fault_cnt if enabled) clears immediately; Y is unaffected. With FAULT_CNT_EN, 300 faulty cycles -> fault_cnt=0xFF.
